gf2_digit_serial_mult: RTL

GF2_DIGIT_SERIAL_MULT -- requirements
Module: gf2_digit_serial_mult

---
 rtl/gf2_mul_pkg.sv | 11 +
 rtl/gf2_digit_mult.sv | 18 +
 rtl/gf2_digit_serial_mult.sv | 111 +++++++++++
 3 files changed

// File: rtl/gf2_mul_pkg.sv
// Shared types and sizing helper for the digit-serial GF(2)[x] multiplier.
package gf2_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Number of D-bit multiplier digits needed to cover an N-bit operand.
  function automatic int unsigned calc_k(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2_digit_mult.sv
// Combinational N x D carry-less partial product: pp = a * digit over GF(2)[x].
module gf2_digit_mult #(
  parameter int unsigned N = 8,
  parameter int unsigned D = 3
) (
  input  logic [N-1:0]   a,
  input  logic [D-1:0]   digit,
  output logic [N+D-2:0] pp
);

  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < D; j++) begin
      if (digit[j]) pp = pp ^ ((N + D - 1)'(a) << j);
    end
  end

endmodule

// File: rtl/gf2_digit_serial_mult.sv
// Digit-serial carry-less multiplier c = a*b, MSB digit of b first, D bits per cycle.
// Optional macro GF2MUL_ACCUM_EN adds acc_en: completed c = (a*b) XOR previous c.
module gf2_digit_serial_mult
  import gf2_mul_pkg::*;
#(
  parameter int unsigned N = 17669,
  parameter int unsigned D = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef GF2MUL_ACCUM_EN
  input  logic           acc_en,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int unsigned K  = calc_k(N, D);
  localparam int unsigned KD = K * D;
  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [CW-1:0] KMAX = CW'(K);

  state_t           state, state_next;
  logic [N-1:0]     a_q;
  logic [KD-1:0]    b_sr;
  logic [2*N-1:0]   acc, acc_next;
  logic [CW-1:0]    cnt;
  logic [N+D-2:0]   pp;
  logic             last_digit;
`ifdef GF2MUL_ACCUM_EN
  logic             acc_en_q;
`endif

  gf2_digit_mult #(.N(N), .D(D)) u_digit (
    .a     (a_q),
    .digit (b_sr[KD-1 -: D]),
    .pp    (pp)
  );

  // Bits shifted past 2N can never fold back down, so truncating acc every step is exact.
  assign acc_next   = (acc << D) ^ (2 * N)'(pp);
  assign last_digit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_sr <= '0;
      acc  <= '0;
      cnt  <= '0;
      c    <= '0;
`ifdef GF2MUL_ACCUM_EN
      acc_en_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q  <= a;
          b_sr <= KD'(b);
          acc  <= '0;
          cnt  <= '0;
`ifdef GF2MUL_ACCUM_EN
          acc_en_q <= acc_en;
`endif
        end
        RUN: begin
          acc  <= acc_next;
          b_sr <= b_sr << D;
          if (cnt != KMAX) cnt <= cnt + CW'(1);
          if (last_digit) begin
`ifdef GF2MUL_ACCUM_EN
            c <= acc_en_q ? (c ^ acc_next) : acc_next;
`else
            c <= acc_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
